// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types and IR field positions.
// Used by the register file, condition-code logic and their consumers.
package lc3_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_idx_t;
    typedef logic [2:0]  nzp_t;

    localparam reg_idx_t R7_IDX = 3'd7;

    localparam int DR_HI  = 11;
    localparam int DR_LO  = 9;
    localparam int SR1_HI = 8;
    localparam int SR1_LO = 6;
    localparam int SR2_HI = 2;
    localparam int SR2_LO = 0;

    localparam nzp_t NZP_N = 3'b100;
    localparam nzp_t NZP_Z = 3'b010;
    localparam nzp_t NZP_P = 3'b001;

endpackage

// File: rtl/regfile_cc_unit_nzp_gen.sv
// Classifies a data word as negative, zero or positive.
// Exactly one nzp bit is set for any input word.
module nzp_gen
    import lc3_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] word,
    output nzp_t             nzp
);

    always_comb begin
        nzp = NZP_P;
        unique case (1'b1)
            (word == '0):    nzp = NZP_Z;
            word[WIDTH-1]:   nzp = NZP_N;
            default:         nzp = NZP_P;
        endcase
    end

endmodule

// File: rtl/regfile_cc_unit.sv
// LC-3 general-purpose registers R0-R7 with NZP and BEN registers.
// Write-back and condition codes are both sourced from the shared bus.
module regfile_cc_unit
    import lc3_pkg::*;
#(
    parameter int   WIDTH     = 16,
    parameter nzp_t RESET_NZP = 3'b010
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [15:0]      IR,
    input  logic [WIDTH-1:0] Bus,
    input  logic             LD_REG,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic             DRMUX,
    input  logic             SR1MUX,
    output logic [WIDTH-1:0] SR1_OUT,
    output logic [WIDTH-1:0] SR2_OUT,
    output logic [2:0]       nzp,
    output logic             BEN
);

    logic [WIDTH-1:0] gpr [8];
    reg_idx_t         dr;
    reg_idx_t         sr1;
    reg_idx_t         sr2;
    nzp_t             bus_nzp;
    logic             ben_next;
    logic             unused_ir;

    assign dr  = DRMUX  ? R7_IDX : IR[DR_HI:DR_LO];
    assign sr1 = SR1MUX ? IR[SR1_HI:SR1_LO] : IR[DR_HI:DR_LO];
    assign sr2 = IR[SR2_HI:SR2_LO];

    assign unused_ir = ^{IR[15:12], IR[5:3]};

    nzp_gen #(
        .WIDTH (WIDTH)
    ) u_nzp_gen (
        .word (Bus),
        .nzp  (bus_nzp)
    );

    // BEN samples the nzp held before this edge, even if LD_CC fires too.
    assign ben_next = |(IR[DR_HI:DR_LO] & nzp);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                gpr[i] <= '0;
            end
        end else if (LD_REG) begin
            gpr[dr] <= Bus;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            nzp <= RESET_NZP;
            BEN <= 1'b0;
        end else begin
            if (LD_CC) begin
                nzp <= bus_nzp;
            end
            if (LD_BEN) begin
                BEN <= ben_next;
            end
        end
    end

    assign SR1_OUT = gpr[sr1];
    assign SR2_OUT = gpr[sr2];

endmodule

// File: tb/tb_regfile_cc_unit.sv
// Directed checks for the LC-3 register file and condition-code unit.
// Inputs change 1ns after the rising edge; outputs are sampled before the next.
module tb_regfile_cc_unit;

    logic        Clk;
    logic        Reset;
    logic [15:0] IR;
    logic [15:0] Bus;
    logic        LD_REG;
    logic        LD_CC;
    logic        LD_BEN;
    logic        DRMUX;
    logic        SR1MUX;
    logic [15:0] SR1_OUT;
    logic [15:0] SR2_OUT;
    logic [2:0]  nzp;
    logic        BEN;

    int total;
    int bad;

    regfile_cc_unit #(
        .WIDTH     (16),
        .RESET_NZP (3'b010)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .IR      (IR),
        .Bus     (Bus),
        .LD_REG  (LD_REG),
        .LD_CC   (LD_CC),
        .LD_BEN  (LD_BEN),
        .DRMUX   (DRMUX),
        .SR1MUX  (SR1MUX),
        .SR1_OUT (SR1_OUT),
        .SR2_OUT (SR2_OUT),
        .nzp     (nzp),
        .BEN     (BEN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        LD_REG = 1'b0;
        LD_CC  = 1'b0;
        LD_BEN = 1'b0;
        DRMUX  = 1'b0;
        SR1MUX = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        IR    = 16'h0000;
        Bus   = 16'h0000;
        idle();
        Reset = 1'b1;
        tick();
        tick();
        chk("rst_sr1", SR1_OUT, 16'h0000);
        chk("rst_sr2", SR2_OUT, 16'h0000);
        chk("rst_nzp", {13'd0, nzp}, 16'h0002);
        chk("rst_ben", {15'd0, BEN}, 16'h0000);

        // loads during reset are discarded
        IR     = 16'h1600;
        Bus    = 16'hFFFF;
        LD_REG = 1'b1;
        LD_CC  = 1'b1;
        tick();
        chk("rst_ld_r3", SR1_OUT, 16'h0000);
        chk("rst_ld_nzp", {13'd0, nzp}, 16'h0002);
        idle();
        Reset = 1'b0;
        tick();

        // write R3 then assert reset asynchronously
        IR     = 16'h1600;
        Bus    = 16'h1234;
        LD_REG = 1'b1;
        tick();
        idle();
        chk("r3_1234", SR1_OUT, 16'h1234);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_r3", SR1_OUT, 16'h0000);
        Reset = 1'b0;
        tick();

        // write BEEF to R3; old value visible in the write cycle
        IR     = 16'h1600;
        Bus    = 16'hBEEF;
        LD_REG = 1'b1;
        #3;
        chk("wr_cycle_old", SR1_OUT, 16'h0000);
        tick();
        idle();
        IR     = 16'h10C0;
        SR1MUX = 1'b1;
        #1;
        chk("sr1_r3_beef", SR1_OUT, 16'hBEEF);
        chk("sr2_r0", SR2_OUT, 16'h0000);

        // DRMUX selects R7 regardless of IR[11:9]
        idle();
        IR     = 16'h1600;
        DRMUX  = 1'b1;
        Bus    = 16'h3001;
        LD_REG = 1'b1;
        tick();
        idle();
        IR = 16'h1607;
        #1;
        chk("r3_kept", SR1_OUT, 16'hBEEF);
        chk("sr2_r7", SR2_OUT, 16'h3001);
        IR = 16'h0E07;
        #1;
        chk("both_r7_sr1", SR1_OUT, 16'h3001);
        chk("both_r7_sr2", SR2_OUT, 16'h3001);

        // condition codes
        IR    = 16'h0000;
        LD_CC = 1'b1;
        Bus   = 16'h8000;
        tick();
        chk("cc_neg", {13'd0, nzp}, 16'h0004);
        Bus = 16'h0000;
        tick();
        chk("cc_zero", {13'd0, nzp}, 16'h0002);
        Bus = 16'h7FFF;
        tick();
        chk("cc_pos", {13'd0, nzp}, 16'h0001);
        LD_CC = 1'b0;
        Bus   = 16'hFFFF;
        tick();
        chk("cc_hold", {13'd0, nzp}, 16'h0001);

        // branch enable
        LD_CC = 1'b1;
        Bus   = 16'h8000;
        tick();
        LD_CC  = 1'b0;
        IR     = 16'h0800;
        LD_BEN = 1'b1;
        tick();
        chk("ben_n_hit", {15'd0, BEN}, 16'h0001);
        IR = 16'h0600;
        tick();
        chk("ben_zp_miss", {15'd0, BEN}, 16'h0000);
        LD_BEN = 1'b0;
        LD_CC  = 1'b1;
        Bus    = 16'h0001;
        tick();
        LD_CC  = 1'b0;
        IR     = 16'h0E00;
        LD_BEN = 1'b1;
        tick();
        chk("ben_nzp_p", {15'd0, BEN}, 16'h0001);
        LD_BEN = 1'b0;
        IR     = 16'h0000;
        tick();
        chk("ben_hold", {15'd0, BEN}, 16'h0001);

        // same-edge LD_CC and LD_BEN: BEN uses old nzp (001)
        IR     = 16'h0400;
        Bus    = 16'h0000;
        LD_CC  = 1'b1;
        LD_BEN = 1'b1;
        tick();
        idle();
        chk("same_edge_nzp", {13'd0, nzp}, 16'h0002);
        chk("same_edge_ben", {15'd0, BEN}, 16'h0000);

        // LD_REG and LD_CC share one bus value
        IR     = 16'h0A00;
        Bus    = 16'h8123;
        LD_REG = 1'b1;
        LD_CC  = 1'b1;
        tick();
        idle();
        chk("dual_r5", SR1_OUT, 16'h8123);
        chk("dual_nzp", {13'd0, nzp}, 16'h0004);

        // unknown bus without strobes changes nothing
        Bus = 16'hxxxx;
        tick();
        tick();
        chk("busx_r5", SR1_OUT, 16'h8123);
        chk("busx_nzp", {13'd0, nzp}, 16'h0004);
        chk("busx_ben", {15'd0, BEN}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
